// File: rtl/drum_voice_engine.sv
// rtl/drum_voice_engine.sv - N-channel debounced square-wave voice engine with sigma-delta mix
//
// Ports:
//   Clk          system clock
//   rst          asynchronous active-low reset
//   trig         raw per-channel triggers (active-high, asynchronous)
//   half_period  per-channel tone half-period in cycles, channel i at [i*CW +: CW]
//   dur          per-channel voice length in cycles, channel i at [i*DW +: DW]
//   mode         0 = polyphonic, 1 = monophonic
//   active       per-channel "voice playing" LED drive
//   level        number of playing channels whose square wave is high
//   speaker      1-bit sigma-delta output, duty = level/NCH
module drum_voice_engine #(
  parameter int NCH = 4,
  parameter int CW  = 18,
  parameter int DW  = 24,
  parameter int DEB = 16
) (
  input  logic                       Clk,
  input  logic                       rst,
  input  logic [NCH-1:0]             trig,
  input  logic [NCH*CW-1:0]          half_period,
  input  logic [NCH*DW-1:0]          dur,
  input  logic                       mode,
  output logic [NCH-1:0]             active,
  output logic [$clog2(NCH+1)-1:0]   level,
  output logic                       speaker
);

  localparam int LW  = $clog2(NCH+1);
  localparam int DBW = $clog2(DEB);

  logic [NCH-1:0] r_sync1;
  logic [NCH-1:0] r_sync2;
  logic [NCH-1:0] r_db;
  logic [NCH-1:0] r_db_d;
  logic [DBW-1:0] r_dbcnt [NCH];

  logic [NCH-1:0] r_play;
  logic [NCH-1:0] r_phase;
  logic [CW-1:0]  r_tcnt [NCH];
  logic [DW-1:0]  r_dcnt [NCH];

  logic [LW-1:0]  r_acc;
  logic [LW-1:0]  r_level;
  logic           r_speaker;

  logic [NCH-1:0] w_hit;
  logic [NCH-1:0] w_valid;
  logic [NCH-1:0] w_start;
  logic [NCH-1:0] w_kill;
  logic           w_taken;
  logic [LW-1:0]  w_pop;
  logic [LW:0]    w_sum;

  // Synchronizer and debouncer: the counter only accumulates while the
  // synchronized input disagrees with the debounced state.
  always_ff @(posedge Clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_db    <= '0;
      r_db_d  <= '0;
      for (int i = 0; i < NCH; i++) r_dbcnt[i] <= '0;
    end else begin
      r_sync1 <= trig;
      r_sync2 <= r_sync1;
      r_db_d  <= r_db;
      for (int i = 0; i < NCH; i++) begin
        if (r_sync2[i] != r_db[i]) begin
          if (r_dbcnt[i] == DBW'(DEB-1)) begin
            r_db[i]    <= ~r_db[i];
            r_dbcnt[i] <= '0;
          end else begin
            r_dbcnt[i] <= r_dbcnt[i] + DBW'(1);
          end
        end else begin
          r_dbcnt[i] <= '0;
        end
      end
    end
  end

  assign w_hit = r_db & ~r_db_d;

  // Start/kill decision. A hit with zero duration is ignored entirely, so it
  // neither starts a voice nor silences others in mono mode. In mono mode the
  // lowest-index valid hit wins and every other channel is forced idle.
  always_comb begin
    w_valid = '0;
    w_start = '0;
    w_kill  = '0;
    w_taken = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      w_valid[i] = w_hit[i] && (dur[i*DW +: DW] != '0);
      if (w_valid[i] && !(mode && w_taken)) w_start[i] = 1'b1;
      if (w_valid[i]) w_taken = 1'b1;
    end
    for (int i = 0; i < NCH; i++) begin
      w_kill[i] = mode && w_taken && !w_start[i];
    end
  end

  // Voice FSM per channel: r_play is the IDLE/PLAY state bit.
  always_ff @(posedge Clk or negedge rst) begin
    if (!rst) begin
      r_play  <= '0;
      r_phase <= '0;
      for (int i = 0; i < NCH; i++) begin
        r_tcnt[i] <= '0;
        r_dcnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (w_start[i]) begin
          r_play[i]  <= 1'b1;
          r_phase[i] <= 1'b0;
          r_tcnt[i]  <= '0;
          r_dcnt[i]  <= dur[i*DW +: DW];
        end else if (w_kill[i] || (r_play[i] && r_dcnt[i] == DW'(1))) begin
          r_play[i]  <= 1'b0;
          r_phase[i] <= 1'b0;
          r_tcnt[i]  <= '0;
          r_dcnt[i]  <= '0;
        end else if (r_play[i]) begin
          r_dcnt[i] <= r_dcnt[i] - DW'(1);
          if (half_period[i*CW +: CW] == '0) begin
            r_phase[i] <= 1'b0;
            r_tcnt[i]  <= '0;
          end else if (r_tcnt[i] >= half_period[i*CW +: CW] - CW'(1)) begin
            // >= keeps the counter bounded if half_period shrinks mid-voice.
            r_phase[i] <= ~r_phase[i];
            r_tcnt[i]  <= '0;
          end else begin
            r_tcnt[i] <= r_tcnt[i] + CW'(1);
          end
        end
      end
    end
  end

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < NCH; i++) begin
      w_pop = w_pop + LW'(r_play[i] & r_phase[i]);
    end
  end

  // First-order sigma-delta modulator with modulus NCH.
  assign w_sum = {1'b0, r_acc} + {1'b0, r_level};

  always_ff @(posedge Clk or negedge rst) begin
    if (!rst) begin
      r_acc     <= '0;
      r_level   <= '0;
      r_speaker <= 1'b0;
    end else begin
      r_level <= w_pop;
      if (w_sum >= (LW+1)'(NCH)) begin
        r_speaker <= 1'b1;
        r_acc     <= LW'(w_sum - (LW+1)'(NCH));
      end else begin
        r_speaker <= 1'b0;
        r_acc     <= LW'(w_sum);
      end
    end
  end

  assign active  = r_play;
  assign level   = r_level;
  assign speaker = r_speaker;

endmodule

// File: tb/tb_drum_voice_engine.sv
// tb/tb_drum_voice_engine.sv - scoreboard bench for drum_voice_engine against an event-level model
module tb_drum_voice_engine;

  localparam int NCH = 4;
  localparam int CW  = 8;
  localparam int DW  = 8;
  localparam int DEB = 4;
  localparam int LW  = $clog2(NCH+1);

  logic              Clk = 1'b0;
  logic              rst;
  logic [NCH-1:0]    trig;
  logic [NCH*CW-1:0] hp_bus;
  logic [NCH*DW-1:0] dur_bus;
  logic              mode;
  logic [NCH-1:0]    active;
  logic [LW-1:0]     level;
  logic              speaker;

  drum_voice_engine #(.NCH(NCH), .CW(CW), .DW(DW), .DEB(DEB)) dut (
    .Clk(Clk), .rst(rst), .trig(trig), .half_period(hp_bus), .dur(dur_bus),
    .mode(mode), .active(active), .level(level), .speaker(speaker)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [NCH-1:0] act;
    int             lvl;
    bit             spk;
    int             cyc;
  } exp_t;

  exp_t q[$];
  int vectors = 0;
  int miscompares = 0;

  int hp_a  [NCH];
  int dur_a [NCH];

  // Model: voices are intervals [vs, ve) of edge numbers; the square wave is
  // derived from the offset inside the interval.
  int cyc;
  int m_t1 [NCH], m_t2 [NCH], m_db [NCH], m_dbp [NCH], m_run [NCH];
  int m_vs [NCH], m_ve [NCH];
  int m_acc, m_lvl, m_spk;

  function automatic bit m_play(int i, int m);
    return (m >= m_vs[i]) && (m < m_ve[i]);
  endfunction

  function automatic bit m_phase(int i, int m);
    if (!m_play(i, m) || hp_a[i] == 0) return 1'b0;
    return (((m - m_vs[i]) / hp_a[i]) % 2) == 1;
  endfunction

  task automatic model_step();
    int n, lvl_new, s, spk_new, acc_new, w;
    bit valid [NCH];
    exp_t e;
    n = cyc + 1;
    if (!rst) begin
      for (int i = 0; i < NCH; i++) begin
        m_t1[i] = 0; m_t2[i] = 0; m_db[i] = 0; m_dbp[i] = 0; m_run[i] = 0;
        m_vs[i] = 0; m_ve[i] = 0;
      end
      m_acc = 0; m_lvl = 0; m_spk = 0;
    end else begin
      lvl_new = 0;
      for (int i = 0; i < NCH; i++) if (m_phase(i, cyc)) lvl_new++;
      s = m_acc + m_lvl;
      if (s >= NCH) begin spk_new = 1; acc_new = s - NCH; end
      else          begin spk_new = 0; acc_new = s;       end
      for (int i = 0; i < NCH; i++)
        valid[i] = (m_db[i] == 1) && (m_dbp[i] == 0) && (dur_a[i] != 0);
      if (mode) begin
        w = -1;
        for (int i = 0; i < NCH; i++) if (valid[i] && w < 0) w = i;
        if (w >= 0) begin
          for (int i = 0; i < NCH; i++) begin
            if (i == w) begin m_vs[i] = n; m_ve[i] = n + dur_a[i]; end
            else if (m_ve[i] > n) m_ve[i] = n;
          end
        end
      end else begin
        for (int i = 0; i < NCH; i++)
          if (valid[i]) begin m_vs[i] = n; m_ve[i] = n + dur_a[i]; end
      end
      for (int i = 0; i < NCH; i++) begin
        m_dbp[i] = m_db[i];
        if (m_t2[i] != m_db[i]) begin
          m_run[i]++;
          if (m_run[i] == DEB) begin m_db[i] = 1 - m_db[i]; m_run[i] = 0; end
        end else begin
          m_run[i] = 0;
        end
        m_t2[i] = m_t1[i];
        m_t1[i] = int'(trig[i]);
      end
      m_lvl = lvl_new; m_spk = spk_new; m_acc = acc_new;
    end
    cyc = n;
    for (int i = 0; i < NCH; i++) e.act[i] = m_play(i, n);
    e.lvl = m_lvl;
    e.spk = m_spk[0];
    e.cyc = n;
    q.push_back(e);
  endtask

  // Inputs are set at a falling edge; tick predicts the next rising edge,
  // queues the prediction and advances to the following falling edge.
  task automatic tick();
    for (int i = 0; i < NCH; i++) begin
      hp_bus[i*CW +: CW]  = hp_a[i][CW-1:0];
      dur_bus[i*DW +: DW] = dur_a[i][DW-1:0];
    end
    model_step();
    @(negedge Clk);
  endtask

  task automatic hold(input logic [NCH-1:0] t, input int n);
    trig = t;
    repeat (n) tick();
  endtask

  task automatic set_ch(input int i, input int hp, input int d);
    hp_a[i] = hp;
    dur_a[i] = d;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge Clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        vectors++;
        if (active !== e.act || int'(level) != e.lvl || speaker !== e.spk) begin
          miscompares++;
          $display("FAIL outputs cyc=%0d got active=%b level=%0d speaker=%b want active=%b level=%0d speaker=%b",
                   e.cyc, active, level, speaker, e.act, e.lvl, e.spk);
        end
      end
    end
  end

  initial begin
    int hcnt [NCH];
    logic [NCH-1:0] t;
    cyc = 0;
    for (int i = 0; i < NCH; i++) set_ch(i, 0, 0);
    mode = 1'b0;
    rst  = 1'b0;
    trig = '0;

    // Reset with random triggers, then a long idle stretch.
    for (int k = 0; k < 10; k++) hold(NCH'($urandom), 1);
    rst = 1'b1;
    hold('0, 1000);

    // Single voice on ch0.
    set_ch(0, 5, 40);
    hold(4'b0001, 60);
    hold(4'b0000, 40);

    // Debounce: a 3-cycle glitch then a 4-cycle pulse on ch1.
    set_ch(1, 3, 20);
    hold(4'b0010, 3);
    hold(4'b0000, 20);
    hold(4'b0010, 4);
    hold(4'b0000, 60);

    // Retrigger ch0 mid-voice.
    hold(4'b0001, 27);
    hold(4'b0000, 6);
    hold(4'b0001, 30);
    hold(4'b0000, 60);

    // dur=0 on ch2, half_period=0 on ch3.
    set_ch(2, 3, 0);
    set_ch(3, 0, 30);
    hold(4'b1100, 50);
    hold(4'b0000, 60);

    // Mono: ch1 running, ch2 hit kills it; then simultaneous ch1/ch3.
    mode = 1'b1;
    set_ch(1, 4, 50);
    set_ch(2, 2, 30);
    set_ch(3, 3, 30);
    hold(4'b0010, 20);
    hold(4'b0110, 20);
    hold(4'b0000, 60);
    hold(4'b1010, 20);
    hold(4'b0000, 70);

    // Full mix: every channel at half_period=1, in phase.
    mode = 1'b0;
    for (int i = 0; i < NCH; i++) set_ch(i, 1, 40);
    hold(4'b1111, 60);
    hold(4'b0000, 60);

    // Randomized episodes.
    for (int ep = 0; ep < 14; ep++) begin
      for (int i = 0; i < NCH; i++) begin
        set_ch(i, $urandom_range(0, 9),
               ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 50));
        hcnt[i] = $urandom_range(1, 12);
      end
      mode = 1'($urandom_range(0, 1));
      t = '0;
      for (int k = 0; k < 250; k++) begin
        for (int i = 0; i < NCH; i++) begin
          hcnt[i]--;
          if (hcnt[i] == 0) begin
            t[i] = ~t[i];
            hcnt[i] = $urandom_range(1, 12);
          end
        end
        if ($urandom_range(0, 99) == 0) mode = ~mode;
        rst = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
        hold(t, 1);
      end
      rst = 1'b1;
      hold('0, 100);
    end

    repeat (2) @(posedge Clk);
    #2;
    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain got %0d pending want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
